pacman_mover: RTL and testbench
===============================

Name: pacman_mover

Overview:
- Movement controller for the player sprite, one stage upstream and downstream of the maze checker.
- On each movement tick it proposes a candidate position on the checker's probe inputs and waits for the checker's registered wall and win flags.
- It then commits or rejects the step, and produces the committed position for the draw/erase logic.
- Buffered turns, Pac-Man style: a requested direction is tried first; if blocked, the current direction is tried.

Parameters:
- START_X, 8'd1, x coordinate of the sprite after reset.
- START_Y, 7'd1, y coordinate of the sprite after reset.
- X_MAX, 8'd158, largest legal x (2x2 sprite footprint on a 160-wide map).
- Y_MAX, 7'd118, largest legal y (2x2 footprint on a 120-high map).
- CHECK_LATENCY, 2, cycles from a probe change until isWhite/win are valid (ROM read plus output register).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- move_tick  in  1  one-cycle pulse requesting one movement step
- dir_req  in  4  {up,down,left,right} key levels; all zero means no new request
- isWhite  in  1  wall flag from the checker for the current probe
- win  in  1  goal flag from the checker for the current probe
- x_probe  out  8  candidate x driven to the checker
- y_probe  out  7  candidate y driven to the checker
- x_pos  out  8  committed sprite x
- y_pos  out  7  committed sprite y
- cur_dir  out  4  one-hot direction currently moving; 0 means stopped
- step_done  out  1  one-cycle pulse when a step resolves (moved or blocked)
- moved  out  1  valid with step_done: 1 = position changed
- busy  out  1  high in any state other than IDLE
- game_won  out  1  sticky goal-reached flag

Behaviour:
- All outputs are registered.
- Reset values: x_pos=x_probe=START_X; y_pos=y_probe=START_Y; cur_dir=0; step_done=moved=busy=game_won=0; state=IDLE; pending request=0.
- Request latch:
  - dir_req is priority-encoded up>down>left>right into one-hot req_dir.
  - req_dir is captured only on an accepted move_tick.
  - A zero dir_req leaves the pending request unchanged.
- States: IDLE, PROBE_REQ, WAIT_REQ, PROBE_CUR, WAIT_CUR, COMMIT, WON.
- IDLE:
  - move_tick with game_won=0 latches the request.
  - Goes to PROBE_REQ if the pending request is nonzero and differs from cur_dir; else PROBE_CUR if cur_dir is nonzero; else COMMIT with moved=0.
  - move_tick arriving while busy=1 is dropped, with no queueing.
- PROBE_REQ / PROBE_CUR:
  - Candidate = x_pos/y_pos stepped one pixel in the tested direction; x_probe/y_probe are loaded with it.
  - Edge clamp: stepping left at x=0, right at x=X_MAX, up at y=0, or down at y=Y_MAX counts as blocked immediately. The probe is not changed and no wait occurs (next state as if isWhite=1).
  - Otherwise go to WAIT_*.
- WAIT_*:
  - Probe is held constant for CHECK_LATENCY cycles; isWhite/win are sampled in the last one.
  - WAIT_REQ, isWhite=0: accept; cur_dir<=req_dir; pending request cleared.
  - WAIT_REQ, isWhite=1: go to PROBE_CUR if cur_dir is nonzero, else COMMIT with moved=0. The pending request is kept for the next tick.
  - WAIT_CUR, isWhite=0: accept.
  - WAIT_CUR, isWhite=1: cur_dir<=0 (stop), then COMMIT with moved=0.
- COMMIT:
  - On accept: x_pos/y_pos<=probe, moved=1.
  - On reject: x_probe/y_probe restored to x_pos/y_pos, moved=0.
  - step_done pulses for exactly this cycle.
  - If accepted and the sampled win=1: game_won<=1, next state WON; else IDLE.
- WON: terminal; ignores move_tick; busy=1; position frozen. Only reset leaves it.
- Worst case per tick: 2 probes, about 2*(CHECK_LATENCY+1)+1 cycles.
- Widths: x arithmetic is 8-bit, y arithmetic is 7-bit; clamps guarantee no wrap-around.
- Reset asserted mid-step: immediate return to the reset values; no partial commit.

Test Plan:
- Reset with START=(1,1), no walls -> x_pos=1, y_pos=1, cur_dir=0, busy=0. Tick with dir_req=0 -> step_done with moved=0 after 1 cycle.
- Open corridor, dir_req=right, tick -> x_probe=2 for 2 cycles, then x_pos=2, cur_dir=right, moved=1. Second tick with keys released -> x_pos=3.
- Moving right, request up into a wall (isWhite=1 for (x,0)) -> up rejected, right tried, x_pos+1. Request still pending; the next tick with the wall removed -> y decrements.
- Moving right into a wall with no alternative -> moved=0, cur_dir=0, x_probe restored to x_pos.
- x_pos=158 moving right -> blocked with no probe change; step_done 1 cycle after PROBE_CUR; cur_dir=0. Likewise y=0 moving up.
- Step into (148,110) with win=1 -> game_won=1, state WON. Further ticks -> no step_done; async reset mid-WAIT -> all outputs return to reset values on the same cycle.

Source files
------------

// File: rtl/pacman_mover.sv
// Player sprite movement controller: proposes candidate positions to the maze checker,
// waits for its wall/win flags, then commits or rejects the step with Pac-Man turn buffering.
module pacman_mover #(
    parameter logic [7:0]  START_X       = 8'd1,
    parameter logic [6:0]  START_Y       = 7'd1,
    parameter logic [7:0]  X_MAX         = 8'd158,
    parameter logic [6:0]  Y_MAX         = 7'd118,
    parameter int unsigned CHECK_LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       move_tick_i,
    input  logic [3:0] dir_req_i,
    input  logic       is_white_i,
    input  logic       win_i,
    output logic [7:0] x_probe_o,
    output logic [6:0] y_probe_o,
    output logic [7:0] x_pos_o,
    output logic [6:0] y_pos_o,
    output logic [3:0] cur_dir_o,
    output logic       step_done_o,
    output logic       moved_o,
    output logic       busy_o,
    output logic       game_won_o
);

    localparam logic [3:0] DirUp    = 4'b1000;
    localparam logic [3:0] DirDown  = 4'b0100;
    localparam logic [3:0] DirLeft  = 4'b0010;
    localparam logic [3:0] DirRight = 4'b0001;
    // Counter preload; the checker flags are sampled when the counter reaches zero.
    localparam logic [3:0] WaitInit = 4'(CHECK_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StProbeReq,
        StWaitReq,
        StProbeCur,
        StWaitCur,
        StCommit,
        StWon
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] req_q, req_d;
    logic [3:0] cur_dir_q, cur_dir_d;
    logic [7:0] x_pos_q, x_pos_d, x_probe_q, x_probe_d;
    logic [6:0] y_pos_q, y_pos_d, y_probe_q, y_probe_d;
    logic       game_won_q, game_won_d;
    logic       moved_q, moved_d;
    logic       step_done_q, busy_q;

    logic [3:0] test_dir;
    logic [3:0] req_new;
    logic [7:0] cand_x;
    logic [6:0] cand_y;
    logic       at_edge;
    logic       go_accept, go_reject;

    function automatic logic [3:0] prio_enc(input logic [3:0] d);
        if (d[3]) return DirUp;
        if (d[2]) return DirDown;
        if (d[1]) return DirLeft;
        if (d[0]) return DirRight;
        return 4'b0000;
    endfunction

    // One-pixel candidate in the direction under test, plus the map-edge clamp.
    always_comb begin
        test_dir = (state_q == StProbeReq) ? req_q : cur_dir_q;
        cand_x   = x_pos_q;
        cand_y   = y_pos_q;
        at_edge  = 1'b0;
        unique case (test_dir)
            DirUp: begin
                at_edge = (y_pos_q == 7'd0);
                cand_y  = y_pos_q - 7'd1;
            end
            DirDown: begin
                at_edge = (y_pos_q == Y_MAX);
                cand_y  = y_pos_q + 7'd1;
            end
            DirLeft: begin
                at_edge = (x_pos_q == 8'd0);
                cand_x  = x_pos_q - 8'd1;
            end
            DirRight: begin
                at_edge = (x_pos_q == X_MAX);
                cand_x  = x_pos_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        cur_dir_d  = cur_dir_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        x_probe_d  = x_probe_q;
        y_probe_d  = y_probe_q;
        game_won_d = game_won_q;
        moved_d    = 1'b0;
        go_accept  = 1'b0;
        go_reject  = 1'b0;
        req_new    = (dir_req_i != 4'b0000) ? prio_enc(dir_req_i) : req_q;

        unique case (state_q)
            StIdle: begin
                if (move_tick_i && !game_won_q) begin
                    req_d = req_new;
                    if (req_new != 4'b0000 && req_new != cur_dir_q) begin
                        state_d = StProbeReq;
                    end else if (cur_dir_q != 4'b0000) begin
                        state_d = StProbeCur;
                    end else begin
                        go_reject = 1'b1;
                    end
                end
            end
            StProbeReq, StProbeCur: begin
                if (at_edge) begin
                    if (state_q == StProbeCur) begin
                        cur_dir_d = 4'b0000;
                        go_reject = 1'b1;
                    end else if (cur_dir_q != 4'b0000) begin
                        state_d = StProbeCur;
                    end else begin
                        go_reject = 1'b1;
                    end
                end else begin
                    x_probe_d = cand_x;
                    y_probe_d = cand_y;
                    cnt_d     = WaitInit;
                    state_d   = (state_q == StProbeReq) ? StWaitReq : StWaitCur;
                end
            end
            StWaitReq: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!is_white_i) begin
                    cur_dir_d = req_q;
                    req_d     = 4'b0000;
                    go_accept = 1'b1;
                end else if (cur_dir_q != 4'b0000) begin
                    state_d = StProbeCur;
                end else begin
                    go_reject = 1'b1;
                end
            end
            StWaitCur: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!is_white_i) begin
                    go_accept = 1'b1;
                end else begin
                    cur_dir_d = 4'b0000;
                    go_reject = 1'b1;
                end
            end
            StCommit: state_d = game_won_q ? StWon : StIdle;
            StWon:    state_d = StWon;
            default:  state_d = StIdle;
        endcase

        // Position and win flag change on entry to COMMIT so they line up with step_done.
        if (go_accept) begin
            state_d    = StCommit;
            x_pos_d    = x_probe_q;
            y_pos_d    = y_probe_q;
            moved_d    = 1'b1;
            game_won_d = game_won_q | win_i;
        end
        if (go_reject) begin
            state_d   = StCommit;
            x_probe_d = x_pos_q;
            y_probe_d = y_pos_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            req_q       <= 4'b0000;
            cur_dir_q   <= 4'b0000;
            x_pos_q     <= START_X;
            y_pos_q     <= START_Y;
            x_probe_q   <= START_X;
            y_probe_q   <= START_Y;
            game_won_q  <= 1'b0;
            moved_q     <= 1'b0;
            step_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            cur_dir_q   <= cur_dir_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            x_probe_q   <= x_probe_d;
            y_probe_q   <= y_probe_d;
            game_won_q  <= game_won_d;
            moved_q     <= moved_d;
            step_done_q <= (state_d == StCommit);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign x_probe_o   = x_probe_q;
    assign y_probe_o   = y_probe_q;
    assign x_pos_o     = x_pos_q;
    assign y_pos_o     = y_pos_q;
    assign cur_dir_o   = cur_dir_q;
    assign step_done_o = step_done_q;
    assign moved_o     = moved_q;
    assign busy_o      = busy_q;
    assign game_won_o  = game_won_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: a registered maze-checker model plus a per-tick movement model
// computed from coordinates and a wall map; directed test-plan steps then a random walk.
module tb_pacman_mover;

    localparam int Lat   = 2;
    localparam int XMax  = 158;
    localparam int YMax  = 118;
    localparam int GoalX = 148;
    localparam int GoalY = 110;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_tick;
    logic [3:0] dir_req;
    logic       is_white = 1'b0;
    logic       win = 1'b0;
    logic [7:0] x_probe, x_pos;
    logic [6:0] y_probe, y_pos;
    logic [3:0] cur_dir;
    logic       step_done, moved, busy, game_won;

    pacman_mover dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .move_tick_i (move_tick),
        .dir_req_i   (dir_req),
        .is_white_i  (is_white),
        .win_i       (win),
        .x_probe_o   (x_probe),
        .y_probe_o   (y_probe),
        .x_pos_o     (x_pos),
        .y_pos_o     (y_pos),
        .cur_dir_o   (cur_dir),
        .step_done_o (step_done),
        .moved_o     (moved),
        .busy_o      (busy),
        .game_won_o  (game_won)
    );

    always #5 clk = ~clk;

    bit wall_map [0:159][0:119];
    bit goal_en;

    // Checker: flags reflect the probe one register stage later.
    always @(posedge clk) begin
        is_white <= wall_map[int'(x_probe)][int'(y_probe)];
        win      <= goal_en && int'(x_probe) == GoalX && int'(y_probe) == GoalY;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference state of the sprite.
    int         m_x, m_y;
    logic [3:0] m_cur, m_pend;
    bit         m_won;

    task automatic m_reset();
        m_x = 1; m_y = 1; m_cur = 4'b0; m_pend = 4'b0; m_won = 1'b0;
    endtask

    function automatic logic [3:0] key_prio(input logic [3:0] k);
        for (int b = 3; b >= 0; b--) if (k[b]) return 4'(1 << b);
        return 4'b0;
    endfunction

    task automatic m_try(input logic [3:0] d, output bit ok, output int cost,
                         output int nx, output int ny);
        nx = m_x; ny = m_y;
        if (d == 4'b1000) ny = ny - 1;
        if (d == 4'b0100) ny = ny + 1;
        if (d == 4'b0010) nx = nx - 1;
        if (d == 4'b0001) nx = nx + 1;
        if (nx < 0 || nx > XMax || ny < 0 || ny > YMax) begin
            ok = 1'b0; cost = 1;
        end else begin
            ok = !wall_map[nx][ny]; cost = Lat + 1;
        end
    endtask

    task automatic m_tick(input logic [3:0] keys, output bit mv, output int lat);
        bit ok; int c, nx, ny;
        lat = 1; mv = 1'b0;
        if (keys != 4'b0) m_pend = key_prio(keys);
        if (m_pend != 4'b0 && m_pend != m_cur) begin
            m_try(m_pend, ok, c, nx, ny);
            lat += c;
            if (ok) begin
                m_x = nx; m_y = ny; m_cur = m_pend; m_pend = 4'b0; mv = 1'b1;
                m_won = goal_en && nx == GoalX && ny == GoalY;
            end
        end
        if (!mv && m_cur != 4'b0) begin
            m_try(m_cur, ok, c, nx, ny);
            lat += c;
            if (ok) begin
                m_x = nx; m_y = ny; mv = 1'b1;
                m_won = goal_en && nx == GoalX && ny == GoalY;
            end else begin
                m_cur = 4'b0;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_x_pos"}, x_pos, 1);
        check_eq({tag, "_y_pos"}, y_pos, 1);
        check_eq({tag, "_x_probe"}, x_probe, 1);
        check_eq({tag, "_y_probe"}, y_probe, 1);
        check_eq({tag, "_cur_dir"}, cur_dir, 0);
        check_eq({tag, "_step_done"}, step_done, 0);
        check_eq({tag, "_moved"}, moved, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_game_won"}, game_won, 0);
    endtask

    // One tick from IDLE; optionally fires dropped ticks while the step is in flight.
    task automatic do_tick(input logic [3:0] keys, input bit spur);
        bit em, seen; int el, n;
        m_tick(keys, em, el);
        @(negedge clk); move_tick = 1'b1; dir_req = keys;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); move_tick = 1'b0; n++;
            if (step_done) seen = 1'b1;
            else if (spur) begin
                move_tick = 1'($urandom_range(0, 1));
                dir_req   = 4'($urandom);
            end
        end
        move_tick = 1'b0;
        check_eq("step_seen", seen, 1);
        check_eq("latency", n, el);
        check_eq("moved", moved, em);
        check_eq("x_pos", x_pos, m_x);
        check_eq("y_pos", y_pos, m_y);
        check_eq("cur_dir", cur_dir, m_cur);
        check_eq("x_probe_rest", x_probe, m_x);
        check_eq("y_probe_rest", y_probe, m_y);
        check_eq("game_won", game_won, m_won);
        @(negedge clk);
        check_eq("pulse_end", step_done, 0);
        check_eq("busy_after", busy, m_won);
    endtask

    initial begin
        bit em, seen; int el, guard;
        rst = 1'b1; move_tick = 1'b0; dir_req = 4'b0; goal_en = 1'b0;
        m_reset();
        #12 check_reset("rst");
        @(negedge clk); rst = 1'b0;

        do_tick(4'b0000, 1'b0);

        // First step right: probe held for the checker latency before the commit.
        m_tick(4'b0001, em, el);
        @(negedge clk); move_tick = 1'b1; dir_req = 4'b0001;
        @(negedge clk); move_tick = 1'b0;
        check_eq("busy_probe", busy, 1);
        @(negedge clk);
        check_eq("probe_hold1", x_probe, 2);
        check_eq("no_early_done", step_done, 0);
        @(negedge clk);
        check_eq("probe_hold2", x_probe, 2);
        check_eq("pos_not_yet", x_pos, 1);
        @(negedge clk);
        check_eq("first_done", step_done, 1);
        check_eq("first_x", x_pos, m_x);
        check_eq("first_moved", moved, 1);
        check_eq("first_dir", cur_dir, 4'b0001);
        @(negedge clk);
        check_eq("first_pulse_end", step_done, 0);

        do_tick(4'b0000, 1'b0);
        wall_map[3][0] = 1'b1;
        do_tick(4'b1000, 1'b0);
        check_eq("turn_fallback_x", x_pos, 4);
        wall_map[3][0] = 1'b0;
        do_tick(4'b0000, 1'b0);
        check_eq("buffered_up_y", y_pos, 0);
        do_tick(4'b0000, 1'b0);
        check_eq("top_edge_stop", cur_dir, 0);

        do_tick(4'b0001, 1'b0);
        wall_map[6][0] = 1'b1;
        do_tick(4'b0000, 1'b0);
        check_eq("wall_stop_dir", cur_dir, 0);
        wall_map[6][0] = 1'b0;

        guard = 0;
        while (m_x < XMax && guard < 200) begin
            do_tick(4'b0001, 1'b1);
            guard++;
        end
        do_tick(4'b0000, 1'b0);
        check_eq("right_edge_x", x_pos, XMax);
        do_tick(4'b0001, 1'b0);

        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                wall_map[x][y] = ($urandom_range(0, 3) == 0);
        wall_map[m_x][m_y] = 1'b0;
        for (int i = 0; i < 250; i++)
            do_tick($urandom_range(0, 1) ? 4'($urandom) : 4'b0000, 1'b1);

        // Reset while waiting on the checker: nothing partial may survive.
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                wall_map[x][y] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; m_reset();
        @(negedge clk); move_tick = 1'b1; dir_req = 4'b0001;
        @(posedge clk); #1 move_tick = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1 check_reset("mid_wait");
        @(negedge clk); rst = 1'b0; m_reset();
        do_tick(4'b0000, 1'b0);

        goal_en = 1'b1;
        guard = 0;
        while (m_y < GoalY && guard < 200) begin do_tick(4'b0100, 1'b0); guard++; end
        while (m_x < GoalX && guard < 400) begin do_tick(4'b0001, 1'b1); guard++; end
        check_eq("won_flag", game_won, 1);

        seen = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); move_tick = 1'b1; dir_req = 4'b0001;
            @(negedge clk); move_tick = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (step_done) seen = 1'b1;
            end
        end
        check_eq("won_no_step", seen, 0);
        check_eq("won_x_frozen", x_pos, GoalX);
        check_eq("won_y_frozen", y_pos, GoalY);
        check_eq("won_busy", busy, 1);

        @(posedge clk); #3 rst = 1'b1;
        #1 check_reset("from_won");
        @(negedge clk); rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
